multicast_sequencer: RTL

MULTICAST_SEQUENCER -- requirements
Module: multicast_sequencer

---
 rtl/multicast_pkg.sv | 22 ++
 rtl/multicast_out_stage.sv | 65 ++++++
 rtl/multicast_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/multicast_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multicast_pkg
//  Brief    : Shared defaults and FSM state encoding for the multicast sequencer.
//  Revision : 1.0
// ============================================================================
package multicast_pkg;

    localparam int c_ADDRESS_WIDTH_DEF = 4;
    localparam int c_BITWIDTH_DEF      = 16;
    localparam int c_NUM_UNITS_DEF     = 4;
    localparam int c_COUNT_WIDTH       = 16;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE   = 2'd0;
    localparam state_t c_ST_CONFIG = 2'd1;
    localparam state_t c_ST_RUN    = 2'd2;
    localparam state_t c_ST_DRAIN  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/multicast_out_stage.sv
`default_nettype none
// ============================================================================
//  Module   : multicast_out_stage
//  Brief    : Single-entry {tag,value} output register with retire and word count.
//  Revision : 1.0
// ============================================================================
module multicast_out_stage
    import multicast_pkg::*;
#(
    parameter int ADDRESS_WIDTH = c_ADDRESS_WIDTH_DEF,
    parameter int BITWIDTH      = c_BITWIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     load,
    input  logic [ADDRESS_WIDTH-1:0] load_tag,
    input  logic [BITWIDTH-1:0]      load_value,
    input  logic                     all_ready,
    output logic                     stage_ready,
    output logic                     out_valid,
    output logic                     mc_enable,
    output logic [ADDRESS_WIDTH-1:0] mc_tag,
    output logic [BITWIDTH-1:0]      mc_value,
    output logic [c_COUNT_WIDTH-1:0] word_count
);

    logic                     r_valid;
    logic [ADDRESS_WIDTH-1:0] r_tag;
    logic [BITWIDTH-1:0]      r_value;
    logic [c_COUNT_WIDTH-1:0] r_count;
    logic                     w_retire;

    // A held word leaves in the same cycle every unit is ready, so a new
    // word may be loaded behind it without a bubble.
    assign w_retire    = r_valid && all_ready;
    assign stage_ready = !r_valid || all_ready;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_value <= '0;
            r_count <= '0;
        end else begin
            if (load) begin
                r_valid <= 1'b1;
                r_tag   <= load_tag;
                r_value <= load_value;
            end else if (w_retire) begin
                r_valid <= 1'b0;
            end
            if (w_retire) begin
                r_count <= r_count + c_COUNT_WIDTH'(1);
            end
        end
    end

    assign out_valid  = r_valid;
    assign mc_enable  = w_retire;
    assign mc_tag     = r_tag;
    assign mc_value   = r_value;
    assign word_count = r_count;

endmodule
`default_nettype wire

// File: rtl/multicast_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : multicast_sequencer
//  Brief    : Programs tag IDs into a controller scan chain, then broadcasts words.
//  Revision : 1.0
// ============================================================================
module multicast_sequencer
    import multicast_pkg::*;
#(
    parameter int ADDRESS_WIDTH = c_ADDRESS_WIDTH_DEF,
    parameter int BITWIDTH      = c_BITWIDTH_DEF,
    parameter int NUM_UNITS     = c_NUM_UNITS_DEF
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     cfg_start,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [ADDRESS_WIDTH-1:0] cfg_tag,
    output logic                     cfg_done,
    output logic                     scan_program,
    output logic [ADDRESS_WIDTH-1:0] scan_tag_out,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDRESS_WIDTH-1:0] in_tag,
    input  logic [BITWIDTH-1:0]      in_value,
    input  logic [NUM_UNITS-1:0]     units_ready,
    output logic                     mc_enable,
    output logic [ADDRESS_WIDTH-1:0] mc_tag,
    output logic [BITWIDTH-1:0]      mc_value,
    output logic [c_COUNT_WIDTH-1:0] word_count
);

    localparam int c_BEAT_W = $clog2(NUM_UNITS + 1);

    state_t                   r_state;
    logic [c_BEAT_W-1:0]      r_beat;
    logic                     r_scan_program;
    logic                     r_cfg_done;
    logic [ADDRESS_WIDTH-1:0] r_scan_tag;

    logic w_all_ready;
    logic w_stage_ready;
    logic w_out_valid;
    logic w_load;
    logic w_valid_next;

    assign w_all_ready = &units_ready;
    assign cfg_ready   = (r_state == c_ST_CONFIG);
    assign in_ready    = (r_state == c_ST_RUN) && w_stage_ready;
    assign w_load      = in_valid && in_ready;
    // Whether a word will still be held after this edge decides DRAIN vs CONFIG.
    assign w_valid_next = w_load || (w_out_valid && !w_all_ready);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state        <= c_ST_IDLE;
            r_beat         <= '0;
            r_scan_program <= 1'b0;
            r_cfg_done     <= 1'b0;
            r_scan_tag     <= '0;
        end else begin
            r_scan_program <= 1'b0;
            r_cfg_done     <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (cfg_start) begin
                        r_state <= c_ST_CONFIG;
                        r_beat  <= '0;
                    end
                end
                c_ST_CONFIG: begin
                    // First tag shifted travels farthest, ending in the last unit.
                    if (cfg_valid) begin
                        r_scan_program <= 1'b1;
                        r_scan_tag     <= cfg_tag;
                        if (r_beat == c_BEAT_W'(NUM_UNITS - 1)) begin
                            r_cfg_done <= 1'b1;
                            r_state    <= c_ST_RUN;
                            r_beat     <= '0;
                        end else begin
                            r_beat <= r_beat + c_BEAT_W'(1);
                        end
                    end
                end
                c_ST_RUN: begin
                    if (cfg_start) begin
                        r_state <= w_valid_next ? c_ST_DRAIN : c_ST_CONFIG;
                        r_beat  <= '0;
                    end
                end
                c_ST_DRAIN: begin
                    if (mc_enable) begin
                        r_state <= c_ST_CONFIG;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign scan_program = r_scan_program;
    assign scan_tag_out = r_scan_tag;
    assign cfg_done     = r_cfg_done;

    multicast_out_stage #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .BITWIDTH      (BITWIDTH)
    ) u_out_stage (
        .clk         (clk),
        .rstb        (rstb),
        .load        (w_load),
        .load_tag    (in_tag),
        .load_value  (in_value),
        .all_ready   (w_all_ready),
        .stage_ready (w_stage_ready),
        .out_valid   (w_out_valid),
        .mc_enable   (mc_enable),
        .mc_tag      (mc_tag),
        .mc_value    (mc_value),
        .word_count  (word_count)
    );

endmodule
`default_nettype wire
